// File: rtl/regs_wr_scoreboard.sv
// Register-write scoreboard for long-latency producers (mul/div, loads).
// Tells ID to stall when a source register is still unproduced.
package regs_wr_scoreboard_pkg;
  typedef struct packed {
    logic RFWr;
  } RegsWrType;
endpackage

module regs_wr_scoreboard
  import regs_wr_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic      ID_rs_used,
  input  logic      ID_rt_used,
  input  logic      issue_valid,
  input  logic [4:0] issue_Dst,
  input  RegsWrType issue_RegsWrType,
  input  logic      issue_long,
  input  logic      WB_valid,
  input  logic [4:0] WB_Dst,
  input  logic      flush,
  output logic      ID_rs_busy,
  output logic      ID_rt_busy,
  output logic      ID_sb_stall,
  output logic      sb_any_pending,
  output logic      sb_err
);

  logic [31:0][1:0] cnt_q, cnt_d;
  logic [2:0]       win_q, win_d;
  logic             err_q, err_d;

  logic inc, dec;
  logic inc_r, dec_r;

  logic [1:0] rs_cnt, rt_cnt, dst_cnt;
  logic       rs_byp, rt_byp;
  logic       dst_sat;

  assign inc = issue_valid & issue_RegsWrType.RFWr
             & issue_long & (issue_Dst != 5'd0);
  assign dec = WB_valid & (WB_Dst != 5'd0);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    win_d = (win_q != 3'd0) ? win_q - 3'd1 : 3'd0;
    inc_r = 1'b0;
    dec_r = 1'b0;
    cnt_d[0] = 2'd0;
    if (flush) begin
      cnt_d = '0;
      win_d = 3'd7;
    end else begin
      for (int r = 1; r < 32; r++) begin
        inc_r = inc & (issue_Dst == 5'(r));
        dec_r = dec & (WB_Dst == 5'(r));
        unique case ({inc_r, dec_r})
          2'b10: begin
            if (cnt_q[r] == 2'd3) err_d = 1'b1;
            else cnt_d[r] = cnt_q[r] + 2'd1;
          end
          2'b01: begin
            // late writebacks after a flush land on cleared counters
            if (cnt_q[r] == 2'd0) begin
              if (win_q == 3'd0) err_d = 1'b1;
            end else begin
              cnt_d[r] = cnt_q[r] - 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      win_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      win_q <= win_d;
      err_q <= err_d;
    end
  end

  assign rs_cnt  = cnt_q[ID_rs];
  assign rt_cnt  = cnt_q[ID_rt];
  assign dst_cnt = cnt_q[issue_Dst];

  // last outstanding write retiring now is forwarded from WB
  assign rs_byp = WB_valid & (WB_Dst == ID_rs) & (rs_cnt == 2'd1);
  assign rt_byp = WB_valid & (WB_Dst == ID_rt) & (rt_cnt == 2'd1);

  assign ID_rs_busy = (ID_rs != 5'd0) & (rs_cnt != 2'd0) & ~rs_byp;
  assign ID_rt_busy = (ID_rt != 5'd0) & (rt_cnt != 2'd0) & ~rt_byp;

  assign dst_sat = issue_RegsWrType.RFWr & issue_long
                 & (issue_Dst != 5'd0) & (dst_cnt == 2'd3)
                 & ~(dec & (WB_Dst == issue_Dst));

  assign ID_sb_stall = (ID_rs_used & ID_rs_busy)
                     | (ID_rt_used & ID_rt_busy)
                     | dst_sat;

  assign sb_any_pending = |cnt_q;
  assign sb_err         = err_q;

endmodule

// File: tb/tb_regs_wr_scoreboard.sv
// Directed bench for regs_wr_scoreboard.
// Inputs change 1ns after posedge; outputs sampled before the next edge.
module tb_regs_wr_scoreboard;
  import regs_wr_scoreboard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_rs, ID_rt;
  logic       ID_rs_used, ID_rt_used;
  logic       issue_valid;
  logic [4:0] issue_Dst;
  RegsWrType  wt;
  logic       issue_long;
  logic       WB_valid;
  logic [4:0] WB_Dst;
  logic       flush;
  logic       ID_rs_busy, ID_rt_busy, ID_sb_stall;
  logic       sb_any_pending, sb_err;

  int checks = 0;
  int failures = 0;

  regs_wr_scoreboard dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .issue_valid(issue_valid), .issue_Dst(issue_Dst),
    .issue_RegsWrType(wt), .issue_long(issue_long),
    .WB_valid(WB_valid), .WB_Dst(WB_Dst), .flush(flush),
    .ID_rs_busy(ID_rs_busy), .ID_rt_busy(ID_rt_busy),
    .ID_sb_stall(ID_sb_stall),
    .sb_any_pending(sb_any_pending), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got,
                     input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_rs = 0; ID_rt = 0; ID_rs_used = 0; ID_rt_used = 0;
    issue_valid = 0; issue_Dst = 0; wt.RFWr = 0; issue_long = 0;
    WB_valid = 0; WB_Dst = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] d);
    issue_valid = 1; issue_Dst = d; wt.RFWr = 1; issue_long = 1;
  endtask

  task automatic wb(input logic [4:0] d);
    WB_valid = 1; WB_Dst = d;
  endtask

  task automatic probe_rs(input logic [4:0] r);
    ID_rs = r; ID_rs_used = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    probe_rs(5); ID_rt = 5; ID_rt_used = 1;
    #1;
    chk("rst_rs_busy", ID_rs_busy, 0);
    chk("rst_rt_busy", ID_rt_busy, 0);
    chk("rst_stall", ID_sb_stall, 0);
    chk("rst_any", sb_any_pending, 0);
    chk("rst_err", sb_err, 0);

    idle(); issue(5); tick();
    idle(); probe_rs(5); #1;
    chk("r5_busy", ID_rs_busy, 1);
    chk("r5_stall", ID_sb_stall, 1);
    chk("r5_any", sb_any_pending, 1);
    wb(5); #1;
    chk("r5_byp_busy", ID_rs_busy, 0);
    chk("r5_byp_stall", ID_sb_stall, 0);
    tick();
    idle(); probe_rs(5); #1;
    chk("r5_clr_busy", ID_rs_busy, 0);
    chk("r5_clr_any", sb_any_pending, 0);

    idle();
    for (int i = 0; i < 3; i++) begin
      issue(7); tick();
    end
    idle(); issue_Dst = 7; wt.RFWr = 1; issue_long = 1; #1;
    chk("r7_sat_stall", ID_sb_stall, 1);
    wb(7); #1;
    chk("r7_sat_wb", ID_sb_stall, 0);
    idle(); issue(7); tick();
    idle(); #1;
    chk("r7_ovf_err", sb_err, 1);
    wb(7); tick();
    wb(7); tick();
    idle(); probe_rs(7); #1;
    chk("r7_cnt1_busy", ID_rs_busy, 1);
    wb(7); #1;
    chk("r7_byp", ID_rs_busy, 0);
    tick();
    idle(); probe_rs(7); #1;
    chk("r7_done_busy", ID_rs_busy, 0);
    chk("r7_done_any", sb_any_pending, 0);
    chk("r7_err_sticky", sb_err, 1);

    idle(); rst = 1; tick(); rst = 0;
    #1;
    chk("rst2_err", sb_err, 0);

    issue(9); tick();
    idle(); issue(9); wb(9); tick();
    idle(); ID_rt = 9; ID_rt_used = 1; #1;
    chk("r9_hold_busy", ID_rt_busy, 1);
    chk("r9_hold_stall", ID_sb_stall, 1);
    chk("r9_err", sb_err, 0);
    idle(); issue(0); tick();
    idle(); issue(9); wt.RFWr = 0; tick();
    idle(); issue(9); issue_long = 0; tick();
    idle(); wb(9); tick();
    idle(); ID_rt = 9; #1;
    chk("r9_nochg_busy", ID_rt_busy, 0);
    chk("r9_nochg_any", sb_any_pending, 0);
    chk("r9_nochg_err", sb_err, 0);

    idle(); issue(3); tick();
    issue(4); tick();
    idle(); flush = 1; issue(3); wb(4); tick();
    idle(); probe_rs(3); #1;
    chk("fl_any", sb_any_pending, 0);
    chk("fl_busy3", ID_rs_busy, 0);
    tick();
    wb(3); tick();
    idle(); #1;
    chk("fl_late_err", sb_err, 0);
    for (int i = 0; i < 9; i++) tick();
    wb(4); tick();
    idle(); #1;
    chk("fl_expired_err", sb_err, 1);

    issue(12); tick();
    issue(12); tick();
    idle(); probe_rs(0); #1;
    chk("r0_busy", ID_rs_busy, 0);
    chk("r0_stall", ID_sb_stall, 0);
    probe_rs(12); #1;
    chk("r12_busy", ID_rs_busy, 1);
    rst = 1; flush = 1; issue(12); tick();
    rst = 0; idle(); probe_rs(12); ID_rt = 12; ID_rt_used = 1; #1;
    chk("rst3_rs_busy", ID_rs_busy, 0);
    chk("rst3_rt_busy", ID_rt_busy, 0);
    chk("rst3_stall", ID_sb_stall, 0);
    chk("rst3_any", sb_any_pending, 0);
    chk("rst3_err", sb_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
